// File: rtl/miner_pkg.sv
// Shared types and constants for the miner nonce scheduler.
package miner_pkg;

  localparam int NONCE_W = 192;
  localparam int HASH_W  = 256;

  typedef logic [NONCE_W-1:0] nonce_t;
  typedef logic [HASH_W-1:0]  hash_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FOUND = 2'd2
  } state_e;

  // Next nonce in the run; wraps from all ones back to zero.
  function automatic nonce_t nonce_inc(input nonce_t n);
    return n + nonce_t'(1);
  endfunction

endpackage

// File: rtl/miner_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the index after the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [N-1:0]  rot_s;
  logic [PW-1:0] off_s;
  logic          hit_s;
  logic [PW:0]   sum_s;
  logic [PW:0]   sum_p1_s;

  // Rotate requests so bit 0 is the pointer position, pick the first one, map back.
  always_comb begin
    rot_s    = N'({req_i, req_i} >> ptr_q);
    off_s    = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit_s && rot_s[i]) begin
        hit_s = 1'b1;
        off_s = PW'(i);
      end
    end
    sum_s = {1'b0, ptr_q} + {1'b0, off_s};
    if (sum_s >= (PW+1)'(N)) begin
      sum_s = sum_s - (PW+1)'(N);
    end else begin
      sum_s = sum_s;
    end
    sum_p1_s = sum_s + (PW+1)'(1);
    gnt_o    = hit_s ? ({{(N-1){1'b0}}, 1'b1} << sum_s) : '0;
    if (clr_i) begin
      ptr_d = '0;
    end else if (advance_i && hit_s) begin
      ptr_d = (sum_s == (PW+1)'(N-1)) ? '0 : sum_p1_s[PW-1:0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/miner_scheduler.sv
// Hands out consecutive nonces to miner cores round-robin and latches the first result.
// Optional MINER_SCHED_LIMIT_EN adds a dispatch limit (Limit_I) and Exhausted_O pulse.
module miner_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 32
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start_I,
  input  logic                              Abort_I,
  input  logic [NONCE_W-1:0]                BaseNonce_I,
  input  logic [NUM_CORES-1:0]              Req_I,
  output logic [NUM_CORES-1:0]              Gnt_O,
  output logic [NONCE_W-1:0]                Nonce_O,
  input  logic [NUM_CORES-1:0]              Found_I,
  input  logic [NUM_CORES-1:0][NONCE_W-1:0] FoundNonce_I,
  input  logic [NUM_CORES-1:0][HASH_W-1:0]  FoundHash_I,
  output logic                              VldNonce_O,
  output logic [NONCE_W-1:0]                ResNonce_O,
  output logic [HASH_W-1:0]                 ResHash_O,
  output logic                              Irq_O,
  input  logic                              IrqClr_I,
  output logic                              Busy_O,
  output logic [CNT_W-1:0]                  DispatchCntr_O
`ifdef MINER_SCHED_LIMIT_EN
  ,
  input  logic [CNT_W-1:0]                  Limit_I,
  output logic                              Exhausted_O
`endif
);

  state_e                 state_q, state_d;
  nonce_t                 next_nonce_q, next_nonce_d;
  nonce_t                 nonce_q, nonce_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic                   vld_q, vld_d;
  logic                   irq_q, irq_d;
  nonce_t                 res_nonce_q, res_nonce_d;
  hash_t                  res_hash_q, res_hash_d;
  logic                   exh_q, exh_d;

  logic                   run_s;
  logic                   start_s;
  logic                   take_s;
  logic [NUM_CORES-1:0]   arb_req_s;
  logic [NUM_CORES-1:0]   arb_gnt_s;
  nonce_t                 fnd_nonce_s;
  hash_t                  fnd_hash_s;

  assign run_s   = (state_q == ST_RUN);
  assign start_s = Start_I & ~Abort_I;
  // A core holding a grant this cycle cannot win again immediately.
  assign arb_req_s = run_s ? (Req_I & ~gnt_q) : '0;
  assign take_s    = run_s & ~Abort_I & ~Start_I & ~(|Found_I) & (|arb_gnt_s);

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .clr_i    (start_s),
    .req_i    (arb_req_s),
    .advance_i(take_s),
    .gnt_o    (arb_gnt_s)
  );

  // Lowest-index asserting core supplies the result data.
  always_comb begin
    fnd_nonce_s = '0;
    fnd_hash_s  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (Found_I[i]) begin
        fnd_nonce_s = FoundNonce_I[i];
        fnd_hash_s  = FoundHash_I[i];
      end
    end
  end

  // Next-state and registered-output logic; Abort beats Start beats Found beats a grant.
  always_comb begin
    state_d      = state_q;
    next_nonce_d = next_nonce_q;
    nonce_d      = nonce_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    vld_d        = 1'b0;
    irq_d        = IrqClr_I ? 1'b0 : irq_q;
    res_nonce_d  = res_nonce_q;
    res_hash_d   = res_hash_q;
    exh_d        = 1'b0;
    if (Abort_I) begin
      state_d = ST_IDLE;
    end else if (Start_I) begin
      state_d      = ST_RUN;
      next_nonce_d = BaseNonce_I;
      cnt_d        = '0;
      irq_d        = 1'b0;
      res_nonce_d  = '0;
      res_hash_d   = '1;
    end else if (run_s && (|Found_I)) begin
      state_d     = ST_FOUND;
      res_nonce_d = fnd_nonce_s;
      res_hash_d  = fnd_hash_s;
      vld_d       = 1'b1;
      irq_d       = 1'b1;
    end else if (take_s) begin
      gnt_d        = arb_gnt_s;
      nonce_d      = next_nonce_q;
      next_nonce_d = nonce_inc(next_nonce_q);
      cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef MINER_SCHED_LIMIT_EN
      if ((Limit_I != '0) && (cnt_d == Limit_I)) begin
        state_d = ST_IDLE;
        exh_d   = 1'b1;
      end else begin
        exh_d   = 1'b0;
      end
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      next_nonce_q <= '0;
      nonce_q      <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      vld_q        <= 1'b0;
      irq_q        <= 1'b0;
      res_nonce_q  <= '0;
      res_hash_q   <= '1;
      exh_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_nonce_q <= next_nonce_d;
      nonce_q      <= nonce_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      vld_q        <= vld_d;
      irq_q        <= irq_d;
      res_nonce_q  <= res_nonce_d;
      res_hash_q   <= res_hash_d;
      exh_q        <= exh_d;
    end
  end

  assign Gnt_O          = gnt_q;
  assign Nonce_O        = nonce_q;
  assign VldNonce_O     = vld_q;
  assign ResNonce_O     = res_nonce_q;
  assign ResHash_O      = res_hash_q;
  assign Irq_O          = irq_q;
  assign Busy_O         = run_s;
  assign DispatchCntr_O = cnt_q;
`ifdef MINER_SCHED_LIMIT_EN
  assign Exhausted_O    = exh_q;
`else
  logic unused_exh_s;
  assign unused_exh_s   = exh_q;
`endif

endmodule

// File: tb/tb_miner_scheduler.sv
// Scoreboard bench for miner_scheduler: expected grants are queued as requests are driven.
module tb_miner_scheduler;
  import miner_pkg::*;

  localparam int NC = 4;
  localparam int CW = 32;
  localparam nonce_t ONES  = '1;
  localparam hash_t  HONES = '1;

  logic                       Clk = 1'b0;
  logic                       Rst = 1'b1;
  logic                       Start_I = 1'b0;
  logic                       Abort_I = 1'b0;
  logic                       IrqClr_I = 1'b0;
  nonce_t                     BaseNonce_I = '0;
  logic [NC-1:0]              Req_I = '0;
  logic [NC-1:0]              Found_I = '0;
  logic [NC-1:0][NONCE_W-1:0] FoundNonce_I = '0;
  logic [NC-1:0][HASH_W-1:0]  FoundHash_I = '0;
  logic [NC-1:0]              Gnt_O;
  nonce_t                     Nonce_O;
  logic                       VldNonce_O;
  nonce_t                     ResNonce_O;
  hash_t                      ResHash_O;
  logic                       Irq_O;
  logic                       Busy_O;
  logic [CW-1:0]              DispatchCntr_O;
`ifdef MINER_SCHED_LIMIT_EN
  logic [CW-1:0]              Limit_I = '0;
  logic                       Exhausted_O;
`endif

  typedef struct packed {
    logic [NC-1:0] gnt;
    nonce_t        nonce;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  miner_scheduler #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Start_I(Start_I), .Abort_I(Abort_I),
    .BaseNonce_I(BaseNonce_I), .Req_I(Req_I), .Gnt_O(Gnt_O), .Nonce_O(Nonce_O),
    .Found_I(Found_I), .FoundNonce_I(FoundNonce_I), .FoundHash_I(FoundHash_I),
    .VldNonce_O(VldNonce_O), .ResNonce_O(ResNonce_O), .ResHash_O(ResHash_O),
    .Irq_O(Irq_O), .IrqClr_I(IrqClr_I), .Busy_O(Busy_O), .DispatchCntr_O(DispatchCntr_O)
`ifdef MINER_SCHED_LIMIT_EN
    , .Limit_I(Limit_I), .Exhausted_O(Exhausted_O)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock, then pop and compare any grant the DUT presents.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    if (Gnt_O !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b nonce=%h, required no grant", Gnt_O, Nonce_O);
      end else begin
        e = exp_q.pop_front();
        if (Gnt_O !== e.gnt || Nonce_O !== e.nonce) begin
          errors++;
          $display("FAIL grant: got gnt=%b nonce=%h, required gnt=%b nonce=%h",
                   Gnt_O, Nonce_O, e.gnt, e.nonce);
        end
      end
    end
  endtask

  task automatic push_grant(input logic [NC-1:0] g, input nonce_t n);
    exp_t e;
    e.gnt   = g;
    e.nonce = n;
    exp_q.push_back(e);
  endtask

  task automatic start_run(input nonce_t base);
    BaseNonce_I = base;
    Start_I = 1'b1;
    tick();
    Start_I = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    checks++; if (Gnt_O !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b required 0000", Gnt_O); end
    checks++; if (Nonce_O !== '0) begin errors++; $display("FAIL reset_nonce: got %h required 0", Nonce_O); end
    checks++; if (VldNonce_O !== 1'b0 || Irq_O !== 1'b0 || Busy_O !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got vld=%b irq=%b busy=%b required 0 0 0", VldNonce_O, Irq_O, Busy_O); end
    checks++; if (DispatchCntr_O !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", DispatchCntr_O); end
    checks++; if (ResNonce_O !== '0 || ResHash_O !== HONES) begin
      errors++; $display("FAIL reset_result: got nonce=%h hash=%h required 0 and all ones", ResNonce_O, ResHash_O); end
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] g;
    start_run(nonce_t'(192'h10));
    Req_I = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % NC);
      push_grant(g, nonce_t'(192'h10) + nonce_t'(k));
    end
    repeat (5) tick();
    Req_I = 4'b0000;
    tick();
    checks++; if (Gnt_O !== 4'b0000) begin errors++; $display("FAIL rr_idle_gnt: got %b required 0000", Gnt_O); end
    checks++; if (DispatchCntr_O !== 32'd5) begin errors++; $display("FAIL rr_cnt: got %0d required 5", DispatchCntr_O); end
    checks++; if (Busy_O !== 1'b1) begin errors++; $display("FAIL rr_busy: got %b required 1", Busy_O); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    start_run(ONES);
    Req_I = 4'b0011;
    push_grant(4'b0001, ONES);
    push_grant(4'b0010, nonce_t'(0));
    repeat (2) tick();
    Req_I = 4'b0000;
    tick();
    checks++; if (DispatchCntr_O !== 32'd2) begin errors++; $display("FAIL wrap_cnt: got %0d required 2", DispatchCntr_O); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_found();
    nonce_t n1, n2;
    hash_t  h1, h2;
    n1 = {6{32'hA1A1_0001}};
    n2 = {6{32'hB2B2_0002}};
    h1 = {8{32'hC3C3_0011}};
    h2 = {8{32'hD4D4_0022}};
    FoundNonce_I[1] = n1; FoundHash_I[1] = h1;
    FoundNonce_I[2] = n2; FoundHash_I[2] = h2;
    Found_I = 4'b0110;
    Req_I = 4'b1111;
    IrqClr_I = 1'b1;
    tick();
    IrqClr_I = 1'b0;
    Found_I = 4'b0100;
    checks++; if (VldNonce_O !== 1'b1) begin errors++; $display("FAIL found_vld: got %b required 1", VldNonce_O); end
    checks++; if (ResNonce_O !== n1 || ResHash_O !== h1) begin
      errors++; $display("FAIL found_data: got nonce=%h hash=%h required nonce=%h hash=%h", ResNonce_O, ResHash_O, n1, h1); end
    checks++; if (Irq_O !== 1'b1) begin errors++; $display("FAIL found_irq_setwins: got %b required 1", Irq_O); end
    checks++; if (Busy_O !== 1'b0 || Gnt_O !== 4'b0000) begin
      errors++; $display("FAIL found_state: got busy=%b gnt=%b required 0 0000", Busy_O, Gnt_O); end
    tick();
    checks++; if (VldNonce_O !== 1'b0 || ResNonce_O !== n1) begin
      errors++; $display("FAIL found_ignored: got vld=%b nonce=%h required 0 %h", VldNonce_O, ResNonce_O, n1); end
    checks++; if (Irq_O !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b required 1", Irq_O); end
    Found_I = 4'b0000;
    Req_I = 4'b0000;
    IrqClr_I = 1'b1;
    tick();
    IrqClr_I = 1'b0;
    checks++; if (Irq_O !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", Irq_O); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL found_missing: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_abort_start();
    start_run(nonce_t'(192'h100));
    checks++; if (ResHash_O !== HONES || Busy_O !== 1'b1) begin
      errors++; $display("FAIL start_clear: got hash=%h busy=%b required all ones 1", ResHash_O, Busy_O); end
    Req_I = 4'b0011;
    push_grant(4'b0001, nonce_t'(192'h100));
    push_grant(4'b0010, nonce_t'(192'h101));
    repeat (2) tick();
    Req_I = 4'b0000;
    Abort_I = 1'b1;
    Start_I = 1'b1;
    tick();
    Abort_I = 1'b0;
    Start_I = 1'b0;
    checks++; if (Busy_O !== 1'b0) begin errors++; $display("FAIL abort_prio_busy: got %b required 0", Busy_O); end
    checks++; if (DispatchCntr_O !== 32'd2) begin errors++; $display("FAIL abort_cnt_kept: got %0d required 2", DispatchCntr_O); end
    Req_I = 4'b1111;
    repeat (2) tick();
    Req_I = 4'b0000;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    start_run(nonce_t'(192'h200));
    Req_I = 4'b1111;
    push_grant(4'b0001, nonce_t'(192'h200));
    tick();
    checks++; if (Gnt_O !== 4'b0001) begin errors++; $display("FAIL rst_pre_gnt: got %b required 0001", Gnt_O); end
    #1 Rst = 1'b1;
    #1;
    checks++; if (Gnt_O !== 4'b0000 || DispatchCntr_O !== 32'd0 || ResHash_O !== HONES) begin
      errors++; $display("FAIL rst_async: got gnt=%b cnt=%0d hash=%h required 0000 0 all ones", Gnt_O, DispatchCntr_O, ResHash_O); end
    Req_I = 4'b0000;
    #1 Rst = 1'b0;
    tick();
    checks++; if (Busy_O !== 1'b0 || Nonce_O !== '0) begin
      errors++; $display("FAIL rst_after: got busy=%b nonce=%h required 0 0", Busy_O, Nonce_O); end
    exp_q.delete();
  endtask

`ifdef MINER_SCHED_LIMIT_EN
  task automatic test_limit();
    Limit_I = 32'd3;
    start_run(nonce_t'(192'h300));
    Req_I = 4'b1111;
    push_grant(4'b0001, nonce_t'(192'h300));
    push_grant(4'b0010, nonce_t'(192'h301));
    push_grant(4'b0100, nonce_t'(192'h302));
    repeat (2) tick();
    checks++; if (Exhausted_O !== 1'b0) begin errors++; $display("FAIL limit_early: got %b required 0", Exhausted_O); end
    tick();
    checks++; if (Exhausted_O !== 1'b1 || Busy_O !== 1'b0) begin
      errors++; $display("FAIL limit_hit: got exh=%b busy=%b required 1 0", Exhausted_O, Busy_O); end
    tick();
    checks++; if (Exhausted_O !== 1'b0) begin errors++; $display("FAIL limit_pulse: got %b required 0", Exhausted_O); end
    Req_I = 4'b0000;
    Limit_I = 32'd0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL limit_missing: got %0d pending required 0", exp_q.size()); end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_found();
    test_abort_start();
    test_reset_mid_run();
`ifdef MINER_SCHED_LIMIT_EN
    test_limit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miner_scheduler.md
MINER_SCHEDULER -- requirements
Module: miner_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of miner cores sharing one nonce space (range 2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the dispatch counter.
REQ-003 Clk  in  1  single clock; all logic on its rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-high.
REQ-005 Start_I  in  1  start or restart a mining run from BaseNonce_I.
REQ-006 Abort_I  in  1  stop the run and return to IDLE.
REQ-007 BaseNonce_I  in  192  first nonce of the run.
REQ-008 Req_I  in  NUM_CORES  per-core request for a new nonce.
REQ-009 Gnt_O  out  NUM_CORES  one-hot grant; Nonce_O is valid while any bit is set.
REQ-010 Nonce_O  out  192  nonce handed to the granted core.
REQ-011 Found_I  in  NUM_CORES  per-core one-cycle pulse: hash met target.
REQ-012 FoundNonce_I / FoundHash_I  in  NUM_CORES x 192 / NUM_CORES x 256  winning core's nonce and hash.
REQ-013 VldNonce_O  out  1  one-cycle pulse when a result is latched.
REQ-014 ResNonce_O / ResHash_O  out  192 / 256  latched result.
REQ-015 Irq_O  out  1  sticky interrupt; IrqClr_I  in  1  clears it.
REQ-016 Busy_O  out  1  high in RUN; DispatchCntr_O  out  CNT_W  grants issued this run.

Function
REQ-017 SHALL implement states IDLE, RUN, FOUND.
REQ-018 Start_I in any state SHALL enter RUN next cycle: next_nonce<=BaseNonce_I, counter<=0, Irq_O<=0, ResNonce_O<=0, ResHash_O<=all ones, round-robin pointer<=0.
REQ-019 Abort_I SHALL enter IDLE next cycle; latched results, Irq_O and counter retained. Abort_I has priority over Start_I.
REQ-020 In RUN, requests sampled in cycle t SHALL yield a registered grant in t+1: exactly one Gnt_O bit, chosen round-robin starting at the index after the last grantee, for one cycle, with Nonce_O=next_nonce.
REQ-021 The granted core's Req_I bit SHALL be ignored in the cycle its Gnt_O is high (no back-to-back double grant).
REQ-022 Each grant SHALL increment next_nonce by 1 modulo 2^192 (all-ones wraps to 0) and increment the counter, saturating at all ones.
REQ-023 In RUN, any Found_I bit SHALL latch FoundNonce_I/FoundHash_I of the lowest-index asserting core, pulse VldNonce_O the next cycle, set Irq_O and enter FOUND.
REQ-024 In the cycle Found_I is seen, the grant computed from that cycle's requests SHALL be suppressed; a grant already on Gnt_O completes.
REQ-025 In IDLE and FOUND, Gnt_O SHALL be 0 and Found_I ignored.
REQ-026 IrqClr_I SHALL clear Irq_O; if the set condition coincides, set wins.
REQ-027 Busy_O SHALL be combinational state==RUN; all other outputs registered.

Reset
REQ-028 On Rst: state IDLE, Gnt_O=0, Nonce_O=0, VldNonce_O=0, Irq_O=0, Busy_O=0, counter=0, ResNonce_O=0, ResHash_O=all ones, pointer=0.

Configuration
REQ-029 Macro MINER_SCHED_LIMIT_EN SHALL add input Limit_I (CNT_W) and output Exhausted_O (1).
REQ-030 With MINER_SCHED_LIMIT_EN, the grant making counter==Limit_I (Limit_I!=0) SHALL move RUN to IDLE and pulse Exhausted_O the next cycle; Found_I in that same cycle wins (FOUND, no Exhausted_O).
REQ-031 Without MINER_SCHED_LIMIT_EN, neither port exists and RUN ends only by Found_I, Abort_I or Start_I.

Structure
REQ-032 Package miner_pkg SHALL hold nonce_t (192 bits), hash_t (256 bits), the state enum, and NONCE_W/HASH_W constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; req, advance in; one-hot gnt out).

Verification
REQ-034 Start with BaseNonce_I=0x10, Req_I=4'b1111 held -> grants cores 0,1,2,3,0,... with Nonce_O 0x10,0x11,0x12,0x13,0x14; counter=5 after 5 grants.
REQ-035 BaseNonce_I=2^192-1, one grant -> Nonce_O=all ones, following grant Nonce_O=0.
REQ-036 Found_I=4'b0110 in one cycle -> core 1 data latched, VldNonce_O pulses once, Irq_O=1, state FOUND, Gnt_O stays 0.
REQ-037 Abort_I and Start_I same cycle in RUN -> IDLE, Busy_O=0; IrqClr_I and Found_I same cycle -> Irq_O=1.
REQ-038 Rst asserted mid-RUN with Gnt_O high -> Gnt_O=0, ResHash_O=all ones, counter=0 immediately.
REQ-039 With MINER_SCHED_LIMIT_EN, Limit_I=3 -> third grant followed by Exhausted_O pulse and IDLE; Limit_I=0 -> runs unbounded.
